// File: rtl/l2_cache_ctrl_pkg.sv
// Shared definitions for the L2 tag-RAM controller: field bounds, states,
// access codes and small way helpers.
package l2_cache_ctrl_pkg;
  localparam int OFFSET_W  = 6;
  localparam int INDEX_W   = 9;
  localparam int TAG_W     = 17;
  localparam int WAYS      = 4;

  localparam int INDEX_LSB = OFFSET_W;
  localparam int INDEX_MSB = OFFSET_W + INDEX_W - 1;
  localparam int TAG_LSB   = OFFSET_W + INDEX_W;
  localparam int TAG_MSB   = TAG_LSB + TAG_W - 1;
  localparam int VALID_BIT = TAG_W;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    UPDATE
  } state_t;

  // Lowest set bit wins; callers guarantee at least one bit is set.
  function automatic logic [1:0] lowest_way(input logic [WAYS-1:0] v);
    lowest_way = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (v[i]) lowest_way = i[1:0];
  endfunction

  function automatic logic [WAYS-1:0] way_onehot(input logic [1:0] w);
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction
endpackage

// File: rtl/l2_cache_ctrl_victim_sel.sv
// Victim way picker: lowest invalid way first, otherwise the tree-PLRU leaf.
module l2_victim_sel
  import l2_cache_ctrl_pkg::*;
(
  input  logic [WAYS-1:0] valid,
  input  logic [2:0]      plru,
  output logic [1:0]      victim
);
  always_comb begin
    victim = '0;
    if (!(&valid))    victim = lowest_way(~valid);
    else if (!plru[0]) victim = {1'b0, plru[1]};
    else               victim = {1'b1, plru[2]};
  end
endmodule

// File: rtl/l2_cache_ctrl.sv
// L2 tag-RAM controller: hit/miss lookup, dirty writeback, refill and tag
// commit, one line request at a time.
module l2_cache_ctrl
  import l2_cache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  output logic        busy,
  output logic        hit,
  output logic        done,
  output logic [1:0]  way_sel,
  output logic [8:0]  l2_index,
  output logic        l2_block0_rw,
  output logic        l2_block1_rw,
  output logic        l2_block2_rw,
  output logic        l2_block3_rw,
  output logic [17:0] l2_tag_wd,
  output logic        l2_dirty_wd,
  input  logic [17:0] l2_tag0_rd,
  input  logic [17:0] l2_tag1_rd,
  input  logic [17:0] l2_tag2_rd,
  input  logic [17:0] l2_tag3_rd,
  input  logic [2:0]  plru,
  input  logic        l2_dirty0,
  input  logic        l2_dirty1,
  input  logic        l2_dirty2,
  input  logic        l2_dirty3,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  input  logic        mem_ready
);
  state_t                          state;
  logic [TAG_MSB:INDEX_LSB]        line_q;
  logic                            rw_q;
  logic                            hit_q;
  logic [WAYS-1:0]                 blk_rw;
  logic [WAYS-1:0][VALID_BIT:0]    tag_rd;
  logic [WAYS-1:0]                 dirty_rd;
  logic [WAYS-1:0]                 valid;
  logic [WAYS-1:0]                 match;
  logic [1:0]                      hit_way;
  logic [1:0]                      victim;
  logic                            unused_offset;

  assign tag_rd   = {l2_tag3_rd, l2_tag2_rd, l2_tag1_rd, l2_tag0_rd};
  assign dirty_rd = {l2_dirty3, l2_dirty2, l2_dirty1, l2_dirty0};
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  genvar w;
  for (w = 0; w < WAYS; w++) begin : g_way
    assign valid[w] = tag_rd[w][VALID_BIT];
    assign match[w] = valid[w] && (tag_rd[w][TAG_W-1:0] == line_q[TAG_MSB:TAG_LSB]);
  end

  assign hit_way = lowest_way(match);

  l2_victim_sel u_victim (
    .valid  (valid),
    .plru   (plru),
    .victim (victim)
  );

  // The tag RAM read for a new request is launched from IDLE so it lands in LOOKUP.
  assign l2_index = (state == IDLE) ? req_addr[INDEX_MSB:INDEX_LSB] : line_q[INDEX_MSB:INDEX_LSB];
  assign busy     = (state != IDLE);

  assign {l2_block3_rw, l2_block2_rw, l2_block1_rw, l2_block0_rw} = blk_rw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      line_q      <= '0;
      rw_q        <= READ;
      hit_q       <= 1'b0;
      hit         <= 1'b0;
      done        <= 1'b0;
      way_sel     <= '0;
      blk_rw      <= '0;
      l2_tag_wd   <= '0;
      l2_dirty_wd <= 1'b0;
      mem_req     <= 1'b0;
      mem_rw      <= READ;
      mem_addr    <= '0;
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            line_q <= req_addr[TAG_MSB:INDEX_LSB];
            rw_q   <= req_rw;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (|match) begin
            way_sel     <= hit_way;
            hit_q       <= 1'b1;
            blk_rw      <= way_onehot(hit_way);
            l2_tag_wd   <= {1'b1, line_q[TAG_MSB:TAG_LSB]};
            l2_dirty_wd <= rw_q | dirty_rd[hit_way];
            state       <= UPDATE;
          end else begin
            way_sel <= victim;
            hit_q   <= 1'b0;
            mem_req <= 1'b1;
            if (valid[victim] && dirty_rd[victim]) begin
              mem_rw   <= WRITE;
              mem_addr <= {tag_rd[victim][TAG_W-1:0], line_q[INDEX_MSB:INDEX_LSB], {OFFSET_W{1'b0}}};
              state    <= WRITEBACK;
            end else begin
              mem_rw   <= READ;
              mem_addr <= {line_q, {OFFSET_W{1'b0}}};
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            mem_rw   <= READ;
            mem_addr <= {line_q, {OFFSET_W{1'b0}}};
            state    <= REFILL;
          end
        end
        REFILL: begin
          // After a writeback the request is re-raised one cycle later as a fresh transfer.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ready) begin
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            blk_rw      <= way_onehot(way_sel);
            l2_tag_wd   <= {1'b1, line_q[TAG_MSB:TAG_LSB]};
            l2_dirty_wd <= rw_q;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          blk_rw      <= '0;
          l2_tag_wd   <= '0;
          l2_dirty_wd <= 1'b0;
          done        <= 1'b1;
          hit         <= hit_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed bench for l2_cache_ctrl with a behavioural tag RAM, memory
// responder and scoreboard queues for memory transfers, commits and dones.
module tb_l2_cache_ctrl;
  typedef struct {
    logic [1:0]  way;
    logic [8:0]  idx;
    logic [17:0] tag_wd;
    logic        dirty;
  } commit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_rw;
  logic [31:0] req_addr;
  logic        busy, hit, done;
  logic [1:0]  way_sel;
  logic [8:0]  l2_index;
  logic        b0, b1, b2, b3;
  logic [17:0] l2_tag_wd;
  logic        l2_dirty_wd;
  logic [3:0][17:0] tag_rd;
  logic [3:0]  dirty_rd;
  logic [2:0]  plru_rd, plru_val;
  logic        mem_req, mem_rw, mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  strobe;

  logic [17:0] tag_mem   [4][512];
  logic        dirty_mem [4][512];
  logic        mem_clr;
  int          mem_lat, mem_cnt;

  logic [3:0]  vs_valid;
  logic [2:0]  vs_plru;
  logic [1:0]  vs_victim;
  logic [1:0]  vtab [8] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd3};

  logic [32:0] exp_mem_q [$];
  commit_t     exp_commit_q [$];
  logic        exp_done_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign strobe = {b3, b2, b1, b0};

  l2_cache_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .busy(busy), .hit(hit), .done(done), .way_sel(way_sel), .l2_index(l2_index),
    .l2_block0_rw(b0), .l2_block1_rw(b1), .l2_block2_rw(b2), .l2_block3_rw(b3),
    .l2_tag_wd(l2_tag_wd), .l2_dirty_wd(l2_dirty_wd),
    .l2_tag0_rd(tag_rd[0]), .l2_tag1_rd(tag_rd[1]), .l2_tag2_rd(tag_rd[2]), .l2_tag3_rd(tag_rd[3]),
    .plru(plru_rd),
    .l2_dirty0(dirty_rd[0]), .l2_dirty1(dirty_rd[1]), .l2_dirty2(dirty_rd[2]), .l2_dirty3(dirty_rd[3]),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_ready(mem_ready)
  );

  l2_victim_sel u_vs (.valid(vs_valid), .plru(vs_plru), .victim(vs_victim));

  // Tag RAM: synchronous read, write on the per-way strobe.
  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (mem_clr) begin
        for (int i = 0; i < 512; i++) begin
          tag_mem[w][i]   <= '0;
          dirty_mem[w][i] <= 1'b0;
        end
      end else if (strobe[w]) begin
        tag_mem[w][l2_index]   <= l2_tag_wd;
        dirty_mem[w][l2_index] <= l2_dirty_wd;
      end
      tag_rd[w]   <= tag_mem[w][l2_index];
      dirty_rd[w] <= dirty_mem[w][l2_index];
    end
    plru_rd <= plru_val;
  end

  // Memory: one-cycle mem_ready pulse mem_lat+1 cycles after mem_req is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt   <= 0;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_req && !mem_ready) begin
        if (mem_cnt >= mem_lat) begin
          mem_ready <= 1'b1;
          mem_cnt   <= 0;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_commit();
    commit_t c;
    chk("strobe_onehot", $countones(strobe), 1);
    chk("commit_expected", exp_commit_q.size() != 0, 1);
    if (exp_commit_q.size() != 0) begin
      c = exp_commit_q.pop_front();
      chk("commit_way", strobe, 4'b0001 << c.way);
      chk("commit_way_sel", way_sel, c.way);
      chk("commit_index", l2_index, c.idx);
      chk("commit_tag_wd", l2_tag_wd, c.tag_wd);
      chk("commit_dirty_wd", l2_dirty_wd, c.dirty);
    end
  endtask

  task automatic mon_done();
    logic h;
    chk("done_expected", exp_done_q.size() != 0, 1);
    if (exp_done_q.size() != 0) begin
      h = exp_done_q.pop_front();
      chk("done_hit", hit, h);
    end
  endtask

  task automatic mon_mem();
    logic [32:0] m;
    chk("mem_expected", exp_mem_q.size() != 0, 1);
    if (exp_mem_q.size() != 0) begin
      m = exp_mem_q.pop_front();
      chk("mem_rw", mem_rw, m[32]);
      chk("mem_addr", mem_addr, m[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (strobe != 4'b0) mon_commit();
      if (done) mon_done();
      if (mem_ready && mem_req) mon_mem();
    end
  end

  function automatic logic [31:0] mk_addr(input logic [16:0] tag, input logic [8:0] idx);
    return {tag, idx, 6'b0};
  endfunction

  task automatic push_commit(input logic [1:0] way, input logic [16:0] tag, input logic dirty);
    commit_t c;
    c.way    = way;
    c.idx    = 9'h08D;
    c.tag_wd = {1'b1, tag};
    c.dirty  = dirty;
    exp_commit_q.push_back(c);
  endtask

  // Drives one request, scrambles the address after acceptance, waits for done.
  task automatic do_req(input logic [31:0] addr, input logic rw, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    @(negedge clk);
    req = 1'b1; req_rw = rw; req_addr = addr;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) req_addr = addr ^ 32'hFFFF_FFC0;
      if (done) begin
        seen = 1;
        break;
      end
    end
    req = 1'b0;
    chk("done_timeout", seen, 1);
    if (exp_lat >= 0) chk("hit_latency", n, exp_lat);
  endtask

  initial begin
    bit got;
    rst = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = '0;
    mem_lat = 2; plru_val = 3'b000; mem_clr = 1'b1;
    vs_valid = '0; vs_plru = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_strobes", strobe, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", {mem_rw, mem_addr}, 0);
    chk("rst_wd", {l2_tag_wd, l2_dirty_wd, way_sel}, 0);
    chk("rst_index", l2_index, 0);
    mem_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int p = 0; p < 8; p++) begin
      vs_valid = 4'hF; vs_plru = p[2:0]; #1;
      chk("victim_plru", vs_victim, vtab[p]);
    end
    vs_valid = 4'b1011; vs_plru = 3'b000; #1;
    chk("victim_invalid2", vs_victim, 2);
    vs_valid = 4'b0110; vs_plru = 3'b111; #1;
    chk("victim_invalid0", vs_victim, 0);

    // Cold read miss
    exp_mem_q.push_back({1'b0, 32'h0001_2340});
    push_commit(2'd0, 17'h00002, 1'b0);
    exp_done_q.push_back(1'b0);
    do_req(32'h0001_2340, 1'b0, -1);

    // Read hit, write hit, read hit retains dirty
    push_commit(2'd0, 17'h00002, 1'b0); exp_done_q.push_back(1'b1);
    do_req(32'h0001_2340, 1'b0, 3);
    push_commit(2'd0, 17'h00002, 1'b1); exp_done_q.push_back(1'b1);
    do_req(32'h0001_2340, 1'b1, 3);
    push_commit(2'd0, 17'h00002, 1'b1); exp_done_q.push_back(1'b1);
    do_req(32'h0001_2340, 1'b0, 3);

    // Fill ways 1..3; way1 through a write miss
    for (int t = 3; t <= 5; t++) begin
      exp_mem_q.push_back({1'b0, mk_addr(t[16:0], 9'h08D)});
      push_commit(t[1:0] - 2'd2, t[16:0], t == 3);
      exp_done_q.push_back(1'b0);
      do_req(mk_addr(t[16:0], 9'h08D), t == 3, -1);
    end

    // Dirty eviction of way0 via PLRU
    plru_val = 3'b000;
    exp_mem_q.push_back({1'b1, 32'h0001_2340});
    exp_mem_q.push_back({1'b0, mk_addr(17'd6, 9'h08D)});
    push_commit(2'd0, 17'd6, 1'b0);
    exp_done_q.push_back(1'b0);
    do_req(mk_addr(17'd6, 9'h08D), 1'b0, -1);

    // Clean eviction of way3 via PLRU right subtree
    plru_val = 3'b101;
    exp_mem_q.push_back({1'b0, mk_addr(17'd8, 9'h08D)});
    push_commit(2'd3, 17'd8, 1'b0);
    exp_done_q.push_back(1'b0);
    do_req(mk_addr(17'd8, 9'h08D), 1'b0, -1);
    plru_val = 3'b000;

    // Reset while REFILL holds mem_req
    mem_lat = 50;
    got = 0;
    @(negedge clk);
    req = 1'b1; req_rw = 1'b0; req_addr = mk_addr(17'd7, 9'h08D);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        got = 1;
        break;
      end
    end
    chk("refill_mem_req_seen", got, 1);
    #2;
    rst = 1'b1; req = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_strobes", strobe, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {busy, done}, 0);

    push_commit(2'd0, 17'd6, 1'b0); exp_done_q.push_back(1'b1);
    do_req(mk_addr(17'd6, 9'h08D), 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("mem_q_drained", exp_mem_q.size(), 0);
    chk("commit_q_drained", exp_commit_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
